// File: rtl/rob_retire.sv
// In-order reorder buffer with dual allocate, triple completion and dual retire.
// Retired entries hand their previous physical register back to the rename free pool.
module rob_retire #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 7,
    parameter int IDX_W  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [1:0]            i_alloc_valid,
    input  logic [2*PREG_W-1:0]   i_alloc_pdst,
    input  logic [2*PREG_W-1:0]   i_alloc_old_pdst,
    input  logic [1:0]            i_alloc_regwrite,
    output logic                  o_alloc_ready,
    output logic [2*IDX_W-1:0]    o_alloc_idx,
    input  logic [2:0]            i_cmpl_valid,
    input  logic [3*IDX_W-1:0]    i_cmpl_idx,
    output logic [1:0]            o_retire_valid,
    output logic [1:0]            o_free_valid,
    output logic [2*PREG_W-1:0]   o_free_preg,
    output logic [IDX_W:0]        o_count,
    output logic                  o_empty,
    output logic                  o_full
);

    localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(DEPTH - 2);
    localparam logic [IDX_W:0] FULL_CNT  = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_reg, valid_next;
    logic [DEPTH-1:0]  done_reg, done_next;
    logic [DEPTH-1:0]  regwrite_mem;
    logic [PREG_W-1:0] pdst_mem     [DEPTH];
    logic [PREG_W-1:0] old_pdst_mem [DEPTH];

    logic [IDX_W-1:0]  head_reg, tail_reg;
    logic [IDX_W:0]    count_reg, count_next;
    logic [1:0]        retire_valid_reg;
    logic [1:0]        free_valid_reg;
    logic [2*PREG_W-1:0] free_preg_reg;

    logic [IDX_W-1:0]  alloc_idx [2];
    logic [IDX_W-1:0]  ret_idx   [2];
    logic [1:0]        accept;
    logic [1:0]        retire;
    logic [1:0]        free_sel;
    logic              alloc_ready;

    assign alloc_ready  = (count_reg <= READY_MAX);
    assign accept       = i_alloc_valid & {2{alloc_ready}};

    // Slot 1 lands on the tail when slot 0 is idle, so no hole is left behind.
    assign alloc_idx[0] = tail_reg;
    assign alloc_idx[1] = tail_reg + IDX_W'(i_alloc_valid[0]);

    assign ret_idx[0]   = head_reg;
    assign ret_idx[1]   = head_reg + IDX_W'(1);

    assign retire[0] = valid_reg[ret_idx[0]] & done_reg[ret_idx[0]];
    assign retire[1] = retire[0] & valid_reg[ret_idx[1]] & done_reg[ret_idx[1]];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign o_alloc_idx[gi*IDX_W +: IDX_W] = alloc_idx[gi];
            // PReg 0 is hardwired and must never reach the free pool.
            assign free_sel[gi] = retire[gi] & regwrite_mem[ret_idx[gi]]
                                & (old_pdst_mem[ret_idx[gi]] != '0);

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    free_preg_reg[gi*PREG_W +: PREG_W] <= '0;
                end else begin
                    free_preg_reg[gi*PREG_W +: PREG_W] <=
                        free_sel[gi] ? old_pdst_mem[ret_idx[gi]] : '0;
                end
            end
        end
    endgenerate

    always_comb begin
        valid_next = valid_reg;
        done_next  = done_reg;
        // Completions only land on entries that were already live before this edge.
        for (int p = 0; p < 3; p++) begin
            if (i_cmpl_valid[p] && valid_reg[i_cmpl_idx[p*IDX_W +: IDX_W]]) begin
                done_next[i_cmpl_idx[p*IDX_W +: IDX_W]] = 1'b1;
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (retire[s]) begin
                valid_next[ret_idx[s]] = 1'b0;
                done_next[ret_idx[s]]  = 1'b0;
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (accept[s]) begin
                valid_next[alloc_idx[s]] = 1'b1;
                done_next[alloc_idx[s]]  = 1'b0;
            end
        end
    end

    always_comb begin
        count_next = count_reg
                   + (IDX_W+1)'(accept[0]) + (IDX_W+1)'(accept[1])
                   - (IDX_W+1)'(retire[0]) - (IDX_W+1)'(retire[1]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_reg        <= '0;
            done_reg         <= '0;
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            retire_valid_reg <= '0;
            free_valid_reg   <= '0;
        end else begin
            valid_reg        <= valid_next;
            done_reg         <= done_next;
            head_reg         <= head_reg + IDX_W'(retire[0]) + IDX_W'(retire[1]);
            tail_reg         <= tail_reg + IDX_W'(accept[0]) + IDX_W'(accept[1]);
            count_reg        <= count_next;
            retire_valid_reg <= retire;
            free_valid_reg   <= free_sel;
        end
    end

    // Payload storage needs no reset; the valid bits qualify every read.
    always_ff @(posedge i_clk) begin
        for (int s = 0; s < 2; s++) begin
            if (accept[s]) begin
                regwrite_mem[alloc_idx[s]] <= i_alloc_regwrite[s];
                pdst_mem[alloc_idx[s]]     <= i_alloc_pdst[s*PREG_W +: PREG_W];
                old_pdst_mem[alloc_idx[s]] <= i_alloc_old_pdst[s*PREG_W +: PREG_W];
            end
        end
    end

    assign o_alloc_ready  = alloc_ready;
    assign o_retire_valid = retire_valid_reg;
    assign o_free_valid   = free_valid_reg;
    assign o_free_preg    = free_preg_reg;
    assign o_count        = count_reg;
    assign o_empty        = (count_reg == '0);
    assign o_full         = (count_reg == FULL_CNT);

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire; expected frees are queued at allocation and
// popped by a monitor whenever the DUT signals a retirement.
module tb_rob_retire;

    localparam int PW = 7;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [1:0]      i_alloc_valid;
    logic [2*PW-1:0] i_alloc_pdst;
    logic [2*PW-1:0] i_alloc_old_pdst;
    logic [1:0]      i_alloc_regwrite;
    logic            o_alloc_ready;
    logic [2*IW-1:0] o_alloc_idx;
    logic [2:0]      i_cmpl_valid;
    logic [3*IW-1:0] i_cmpl_idx;
    logic [1:0]      o_retire_valid;
    logic [1:0]      o_free_valid;
    logic [2*PW-1:0] o_free_preg;
    logic [IW:0]     o_count;
    logic            o_empty;
    logic            o_full;

    int n_cmp = 0;
    int n_err = 0;

    // Each entry: {free_valid, free_preg} expected at retirement, in program order.
    logic [PW:0] sb[$];
    logic [PW:0] exp_e;

    rob_retire #(.DEPTH(16), .PREG_W(PW), .IDX_W(IW)) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_alloc_valid    (i_alloc_valid),
        .i_alloc_pdst     (i_alloc_pdst),
        .i_alloc_old_pdst (i_alloc_old_pdst),
        .i_alloc_regwrite (i_alloc_regwrite),
        .o_alloc_ready    (o_alloc_ready),
        .o_alloc_idx      (o_alloc_idx),
        .i_cmpl_valid     (i_cmpl_valid),
        .i_cmpl_idx       (i_cmpl_idx),
        .o_retire_valid   (o_retire_valid),
        .o_free_valid     (o_free_valid),
        .o_free_preg      (o_free_preg),
        .o_count          (o_count),
        .o_empty          (o_empty),
        .o_full           (o_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        i_alloc_valid    = '0;
        i_alloc_pdst     = '0;
        i_alloc_old_pdst = '0;
        i_alloc_regwrite = '0;
        i_cmpl_valid     = '0;
        i_cmpl_idx       = '0;
    endtask

    task automatic set_alloc(input logic [1:0] v, input logic [PW-1:0] old0, input logic rw0,
                             input logic [PW-1:0] old1, input logic rw1, input bit push);
        logic f0, f1;
        i_alloc_valid    = v;
        i_alloc_old_pdst = {old1, old0};
        i_alloc_pdst     = {old1 + 7'd64, old0 + 7'd64};
        i_alloc_regwrite = {rw1, rw0};
        f0 = rw0 && (old0 != 0);
        f1 = rw1 && (old1 != 0);
        if (push) begin
            if (v[0]) sb.push_back({f0, f0 ? old0 : 7'd0});
            if (v[1]) sb.push_back({f1, f1 ? old1 : 7'd0});
        end
    endtask

    task automatic cmpl(input logic [2:0] v, input logic [IW-1:0] a0,
                        input logic [IW-1:0] a1, input logic [IW-1:0] a2);
        i_cmpl_valid = v;
        i_cmpl_idx   = {a2, a1, a0};
    endtask

    task automatic do_reset();
        clr();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_empty(input int max_cycles);
        int k = 0;
        while (o_count != 0 && k < max_cycles) begin
            tick();
            k++;
        end
        check("drain_count", o_count, 0);
    endtask

    // Monitor: every retiring slot must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (o_retire_valid[s] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_retire slot%0d: got retire, expected none (t=%0t)", s, $time);
                end else begin
                    exp_e = sb.pop_front();
                    check($sformatf("free_valid_s%0d", s), 32'(o_free_valid[s]), 32'(exp_e[PW]));
                    check($sformatf("free_preg_s%0d", s), 32'(o_free_preg[s*PW +: PW]), 32'(exp_e[PW-1:0]));
                end
            end else begin
                check($sformatf("idle_free_valid_s%0d", s), 32'(o_free_valid[s]), 0);
                check($sformatf("idle_free_preg_s%0d", s), 32'(o_free_preg[s*PW +: PW]), 0);
            end
        end
    end

    initial begin
        clr();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;

        // Reset state
        check("rst_count", o_count, 0);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_ready", o_alloc_ready, 1);
        check("rst_retire", o_retire_valid, 0);
        check("rst_free_preg", o_free_preg, 0);

        // Pair allocate, complete next edge, retire two edges after allocate
        set_alloc(2'b11, 7'd5, 1'b1, 7'd6, 1'b1, 1'b1);
        #1;
        check("t2_alloc_idx", o_alloc_idx, {4'd1, 4'd0});
        tick();
        clr();
        cmpl(3'b011, 4'd0, 4'd1, 4'd0);
        tick();
        clr();
        check("t2_no_early_retire", o_retire_valid, 0);
        check("t2_count2", o_count, 2);
        tick();
        check("t2_retire", o_retire_valid, 2'b11);
        check("t2_free_valid", o_free_valid, 2'b11);
        check("t2_free_preg", o_free_preg, {7'd6, 7'd5});
        check("t2_count0", o_count, 0);

        // Head blocking: younger entries done, head not
        do_reset();
        set_alloc(2'b11, 7'd10, 1'b1, 7'd11, 1'b1, 1'b1);
        tick();
        set_alloc(2'b11, 7'd12, 1'b1, 7'd13, 1'b1, 1'b1);
        tick();
        clr();
        cmpl(3'b111, 4'd3, 4'd2, 4'd1);
        tick();
        clr();
        tick();
        check("t3_blocked_a", o_retire_valid, 0);
        tick();
        check("t3_blocked_b", o_retire_valid, 0);
        check("t3_count4", o_count, 4);
        cmpl(3'b001, 4'd0, 4'd0, 4'd0);
        tick();
        clr();
        tick();
        check("t3_retire_01", o_retire_valid, 2'b11);
        check("t3_count2", o_count, 2);
        tick();
        check("t3_retire_23", o_retire_valid, 2'b11);
        check("t3_count0", o_count, 0);

        // Fill to 15, ignored allocate, retire two, wrap the tail
        do_reset();
        for (int i = 0; i < 7; i++) begin
            set_alloc(2'b11, 7'(20 + 2*i), 1'b1, 7'(21 + 2*i), 1'b1, 1'b1);
            tick();
        end
        set_alloc(2'b01, 7'd34, 1'b1, 7'd0, 1'b0, 1'b1);
        tick();
        clr();
        check("t4_count15", o_count, 15);
        check("t4_not_ready", o_alloc_ready, 0);
        check("t4_not_full", o_full, 0);
        set_alloc(2'b01, 7'd99, 1'b1, 7'd0, 1'b0, 1'b0);
        #1;
        check("t4_idx_tail15", o_alloc_idx[IW-1:0], 15);
        tick();
        clr();
        check("t4_ignored_count", o_count, 15);
        cmpl(3'b011, 4'd0, 4'd1, 4'd0);
        tick();
        clr();
        tick();
        check("t4_retire2", o_retire_valid, 2'b11);
        check("t4_count13", o_count, 13);
        check("t4_ready_back", o_alloc_ready, 1);
        set_alloc(2'b11, 7'd40, 1'b1, 7'd41, 1'b1, 1'b1);
        #1;
        check("t4_wrap_idx", o_alloc_idx, {4'd0, 4'd15});
        tick();
        clr();
        check("t4_count15b", o_count, 15);
        for (int g = 0; g < 5; g++) begin
            cmpl(3'b111, 4'((2 + 3*g) % 16), 4'((3 + 3*g) % 16), 4'((4 + 3*g) % 16));
            tick();
        end
        clr();
        wait_empty(40);
        tick();
        check("t4_sb_drained", sb.size(), 0);
        check("t4_empty", o_empty, 1);

        // No-free retirements and completions to dead entries (head=tail=1 here)
        set_alloc(2'b10, 7'd0, 1'b0, 7'd0, 1'b1, 1'b1);
        cmpl(3'b100, 4'd0, 4'd0, 4'd5);
        #1;
        check("t5_slot1_alone_idx", o_alloc_idx[2*IW-1:IW], 1);
        tick();
        clr();
        set_alloc(2'b01, 7'd7, 1'b0, 7'd0, 1'b0, 1'b1);
        #1;
        check("t5_slot0_idx", o_alloc_idx[IW-1:0], 2);
        tick();
        clr();
        cmpl(3'b011, 4'd1, 4'd2, 4'd0);
        tick();
        clr();
        tick();
        check("t5_retire_nofree", o_retire_valid, 2'b11);
        check("t5_free_valid0", o_free_valid, 2'b00);
        check("t5_free_preg0", o_free_preg, 0);
        set_alloc(2'b11, 7'd50, 1'b1, 7'd51, 1'b1, 1'b1);
        tick();
        set_alloc(2'b01, 7'd52, 1'b1, 7'd0, 1'b0, 1'b1);
        cmpl(3'b111, 4'd5, 4'd3, 4'd4);
        tick();
        clr();
        tick();
        check("t5_retire_34", o_retire_valid, 2'b11);
        check("t5_count1", o_count, 1);
        tick();
        tick();
        check("t5_entry5_blocked", o_retire_valid, 0);
        check("t5_count1b", o_count, 1);
        cmpl(3'b001, 4'd5, 4'd0, 4'd0);
        tick();
        clr();
        tick();
        check("t5_retire_5", o_retire_valid, 2'b01);
        check("t5_free_5", o_free_valid, 2'b01);
        check("t5_count0", o_count, 0);

        // Reset mid-operation with six live entries, three done
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(2'b11, 7'(70 + 2*i), 1'b1, 7'(71 + 2*i), 1'b1, 1'b1);
            tick();
        end
        clr();
        cmpl(3'b111, 4'd1, 4'd2, 4'd3);
        tick();
        clr();
        check("t6_count6", o_count, 6);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        sb.delete();
        check("t6_rst_count", o_count, 0);
        check("t6_rst_retire", o_retire_valid, 0);
        check("t6_rst_free", o_free_valid, 0);
        check("t6_rst_empty", o_empty, 1);
        tick();
        check("t6_post_retire", o_retire_valid, 0);
        set_alloc(2'b11, 7'd60, 1'b1, 7'd61, 1'b1, 1'b1);
        #1;
        check("t6_idx_restart", o_alloc_idx, {4'd1, 4'd0});
        tick();
        clr();
        cmpl(3'b011, 4'd0, 4'd1, 4'd0);
        tick();
        clr();
        tick();
        check("t6_retire", o_retire_valid, 2'b11);
        check("t6_count0", o_count, 0);
        tick();
        check("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
In-order reorder buffer and retire stage that closes the rename loop. It accepts up to two renamed instructions per cycle, records destination and previous physical registers, and takes completion notices from up to three execution ports. It retires up to two instructions per cycle in program order and returns each retired instruction's old physical register to the rename free pool.

Parameters:
DEPTH, 16, number of ROB entries; must be a power of 2 and at least 4
PREG_W, 7, physical register address width (128 PRegs)
IDX_W, 4, entry index width; equals log2(DEPTH)

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_rst  input  1  reset; synchronous, active-high
i_alloc_valid  input  2x1  per-slot allocate request from rename; slot 0 is older
i_alloc_pdst  input  2xPREG_W  new destination PReg
i_alloc_old_pdst  input  2xPREG_W  previous mapping of the destination AReg
i_alloc_regwrite  input  2x1  instruction writes a register
o_alloc_ready  output  1  combinational; 1 when count <= DEPTH-2
o_alloc_idx  output  2xIDX_W  combinational; entry index each slot receives if accepted
i_cmpl_valid  input  3x1  completion strobe per execution port
i_cmpl_idx  input  3xIDX_W  entry index completed
o_retire_valid  output  2x1  registered; slot retired this cycle, slot 0 older
o_free_valid  output  2x1  registered; o_free_preg valid for return to rename
o_free_preg  output  2xPREG_W  registered; PReg to release
o_count  output  IDX_W+1  registered occupancy
o_empty  output  1  count == 0
o_full  output  1  count == DEPTH

Behaviour:
- State: circular array of entries {valid, done, regwrite, pdst, old_pdst}, plus head, tail and count registers. Pointers wrap modulo DEPTH.
- Reset (i_rst=1 at an edge): head=tail=count=0; every valid and done bit cleared; o_retire_valid=o_free_valid=0; o_free_preg=0. After reset, o_empty=1 and o_alloc_ready=1. Reset mid-operation discards all entries and emits no frees.
- Allocation: a slot is accepted when i_alloc_valid[s] && o_alloc_ready.
  - o_alloc_idx[0]=tail; o_alloc_idx[1]=tail+i_alloc_valid[0], wrapping.
  - Slot 1 alone takes the tail entry.
  - A new entry is written with valid=1 and done=0. tail advances by the number of accepted slots.
  - While o_alloc_ready=0, no slot is accepted and inputs are ignored.
- Completion: at the edge, for each port p with i_cmpl_valid[p], set done of entry i_cmpl_idx[p] if that entry is already valid.
  - Completion to an invalid entry, including one allocated on the same edge, is ignored.
  - Duplicate or simultaneous completions of the same index are idempotent.
- Retire, evaluated on registered state before the edge:
  - r0 = valid[head] && done[head].
  - r1 = r0 && valid[head+1] && done[head+1].
  - At the edge, retired entries clear valid and done, head advances by r0+r1, and o_retire_valid <= {r1,r0}.
  - o_free_valid[s] <= retired && regwrite && old_pdst != 0; o_free_preg[s] <= old_pdst when o_free_valid is set, else 0.
  - PReg 0 is never freed.
- Latency: minimum allocate-to-retire is 2 edges (allocate at E, complete at E+1, retire at E+2). A completion sampled at edge E yields o_retire_valid high in the cycle after E+1.
- Head blocking: an entry that is not done blocks all younger entries, even if they are done.
- Count: count <= count + accepted − retired, on the same edge. Simultaneous allocate and retire are legal. o_alloc_ready uses the pre-edge count and never accounts for retires on the same edge.
- Wrap-around: head+1 and tail+1 wrap from DEPTH-1 to 0. Full and empty are distinguished only by count.
- Outputs not listed as combinational are registered. o_empty and o_full are decoded from the count register.

Test Plan:
- Reset then idle → o_count=0, o_empty=1, o_alloc_ready=1, o_retire_valid=00, o_free_preg=0.
- Allocate 2 (pdst 32/33, old 5/6, regwrite 1), complete idx 0 and 1 on the next edge → two edges later o_retire_valid=11, o_free_preg={5,6}, o_free_valid=11, o_count=0.
- Allocate idx 0..3, complete 3, 2, 1 only → no retire. Then complete 0 → retire 0,1, then 2,3 on consecutive cycles in order.
- Fill to count=15 → o_alloc_ready=0, and a single-slot allocate is ignored. Retire 2 → ready returns. The tail wraps 15→0, and o_alloc_idx and frees stay correct across the wrap.
- Entry with regwrite=0 or old_pdst=0 retires → o_retire_valid=1, o_free_valid=0, o_free_preg=0. A completion to an unallocated idx leaves no done bit set.
- i_rst asserted with 6 entries, 3 done → next cycle count=0 and no retire/free. Post-reset allocation starts at idx 0.
